// File: rtl/instr_fetch_queue.sv
// Sequential instruction prefetcher: a QUEUE_DEPTH-entry FIFO between the I-cache and the Decoder.
// Optional static JAL target prediction is enabled by defining STATIC_JAL_PREDICT_EN.
module instr_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [31:0] back_pc,
  output logic        start_fetch,
  output logic [31:0] fetch_pc,
  input  logic        instr_ready_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] instr_addr_in,
  input  logic        instr_issued,
  output logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic [31:0] instr_pred_pc
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic {
    ST_REQ     = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [31:0]      fetch_pc_r, fetch_pc_s;
  logic [PTR_W-1:0] head_r, head_s, tail_r, tail_s;
  logic [PTR_W:0]   count_r, count_s;
  logic             started_r;
  logic             full_s, empty_s, enq_s, deq_s;
  logic [31:0]      next_pc_s;

  logic [31:0] instr_mem_r [QUEUE_DEPTH];
  logic [31:0] addr_mem_r  [QUEUE_DEPTH];
  logic [31:0] pred_mem_r  [QUEUE_DEPTH];

  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == '0);
  assign fetch_pc = fetch_pc_r;
  // No request goes out before the first ready cycle after reset, and never into a full queue.
  assign start_fetch = (state_r == ST_REQ) && !full_s && (started_r || rdy);

  // Sequential successor of the returned instruction, optionally redirected by a JAL.
  always_comb begin
    next_pc_s = instr_addr_in + 32'd4;
`ifdef STATIC_JAL_PREDICT_EN
    if (instr_in[6:0] == 7'b1101111) begin
      next_pc_s = instr_addr_in + {{12{instr_in[31]}}, instr_in[19:12], instr_in[20],
                                   instr_in[30:21], 1'b0};
    end else begin
      next_pc_s = instr_addr_in + 32'd4;
    end
`endif
  end

  // Next-state logic: flush, response acceptance and FIFO pointer/count bookkeeping.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    head_s     = head_r;
    tail_s     = tail_r;
    count_s    = count_r;
    enq_s      = 1'b0;
    deq_s      = 1'b0;
    if (rob_clear) begin
      head_s     = '0;
      tail_s     = '0;
      count_s    = '0;
      fetch_pc_s = back_pc;
      // A request left unanswered by the flush will still come back and must be swallowed.
      case (state_r)
        ST_REQ:     state_s = (start_fetch && !instr_ready_in) ? ST_DISCARD : ST_REQ;
        ST_DISCARD: state_s = instr_ready_in ? ST_REQ : ST_DISCARD;
        default:    state_s = ST_REQ;
      endcase
    end else begin
      deq_s = instr_issued && !empty_s;
      case (state_r)
        ST_REQ: begin
          state_s = ST_REQ;
          if (instr_ready_in && (instr_addr_in == fetch_pc_r) && (!full_s || deq_s)) begin
            enq_s      = 1'b1;
            fetch_pc_s = next_pc_s;
          end else begin
            enq_s      = 1'b0;
            fetch_pc_s = fetch_pc_r;
          end
        end
        ST_DISCARD: begin
          if (instr_ready_in) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_DISCARD;
          end
        end
        default: state_s = ST_REQ;
      endcase
      if (enq_s) begin
        tail_s = tail_r + PTR_ONE;
      end else begin
        tail_s = tail_r;
      end
      if (deq_s) begin
        head_s = head_r + PTR_ONE;
      end else begin
        head_s = head_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_s = count_r + CNT_ONE;
        2'b01:   count_s = count_r - CNT_ONE;
        default: count_s = count_r;
      endcase
    end
  end

  // State, pointer and FIFO storage registers; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_REQ;
      fetch_pc_r <= RESET_PC;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      started_r  <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        addr_mem_r[i]  <= 32'h0000_0000;
        pred_mem_r[i]  <= 32'h0000_0000;
      end
    end else if (rdy) begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      count_r    <= count_s;
      started_r  <= 1'b1;
      if (enq_s) begin
        instr_mem_r[tail_r] <= instr_in;
        addr_mem_r[tail_r]  <= instr_addr_in;
        pred_mem_r[tail_r]  <= next_pc_s;
      end
    end
  end

  // Head entry presented to the Decoder; forced to zero while the queue is empty.
  always_comb begin
    if (!empty_s) begin
      instr_ready   = 1'b1;
      instr         = instr_mem_r[head_r];
      instr_addr    = addr_mem_r[head_r];
      instr_pred_pc = pred_mem_r[head_r];
    end else begin
      instr_ready   = 1'b0;
      instr         = 32'h0000_0000;
      instr_addr    = 32'h0000_0000;
      instr_pred_pc = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, hand sequences and randomized cache traffic
// checked against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int D = 4;
`ifdef STATIC_JAL_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        rob_clear = 1'b0;
  logic [31:0] back_pc = 32'h0;
  logic        start_fetch;
  logic [31:0] fetch_pc;
  logic        instr_ready_in = 1'b0;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] instr_addr_in = 32'h0;
  logic        instr_issued = 1'b0;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic [31:0] instr_pred_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.QUEUE_DEPTH(D), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .back_pc(back_pc),
    .start_fetch(start_fetch), .fetch_pc(fetch_pc), .instr_ready_in(instr_ready_in),
    .instr_in(instr_in), .instr_addr_in(instr_addr_in), .instr_issued(instr_issued),
    .instr_ready(instr_ready), .instr(instr), .instr_addr(instr_addr),
    .instr_pred_pc(instr_pred_pc)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] addr;
    logic [31:0] pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          m_disc;
  bit          m_started;

  function automatic logic [31:0] ref_next(input logic [31:0] ins, input logic [31:0] addr);
    logic [20:0] j;
    int          off;
    if (PRED_EN && ins[6:0] == 7'b1101111) begin
      j   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      off = int'(j);
      if (j[20]) off = off - (1 << 21);
      return addr + 32'(off);
    end
    return addr + 32'd4;
  endfunction

  function automatic bit model_sf(input logic r);
    return !m_disc && (mq.size() < D) && (m_started || r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; instr_ready_in = 1'b0; instr_issued = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    m_fpc = 32'h0; m_disc = 1'b0; m_started = 1'b0;
  endtask

  // One clock: drive inputs, compare DUT with model, then advance the model at the edge.
  task automatic step(input logic r, input logic clr, input logic [31:0] bpc, input logic irin,
                      input logic [31:0] iaddr, input logic [31:0] iins, input logic iss);
    bit   sf, deq, enq;
    ent_t e;
    @(negedge clk);
    rdy = r; rob_clear = clr; back_pc = bpc; instr_ready_in = irin;
    instr_addr_in = iaddr; instr_in = iins; instr_issued = iss;
    #1;
    sf = model_sf(r);
    chk("start_fetch", {31'd0, start_fetch}, {31'd0, sf});
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("instr_ready", {31'd0, instr_ready}, (mq.size() > 0) ? 32'd1 : 32'd0);
    chk("instr", instr, (mq.size() > 0) ? mq[0].ins : 32'd0);
    chk("instr_addr", instr_addr, (mq.size() > 0) ? mq[0].addr : 32'd0);
    chk("instr_pred_pc", instr_pred_pc, (mq.size() > 0) ? mq[0].pred : 32'd0);
    @(posedge clk);
    if (r) begin
      m_started = 1'b1;
      if (clr) begin
        mq.delete();
        m_fpc  = bpc;
        m_disc = m_disc ? !irin : (sf && !irin);
      end else begin
        deq = iss && (mq.size() > 0);
        enq = !m_disc && irin && (iaddr == m_fpc) && ((mq.size() < D) || deq);
        if (m_disc && irin) m_disc = 1'b0;
        if (deq) void'(mq.pop_front());
        if (enq) begin
          e.ins = iins; e.addr = iaddr; e.pred = ref_next(iins, iaddr);
          mq.push_back(e);
          m_fpc = e.pred;
        end
      end
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        clr;
    logic [31:0] bpc;
    logic        irin;
    logic [31:0] iaddr;
    logic        iss;
    logic        e_sf;
    logic [31:0] e_fpc;
    logic        e_rdy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[19];

  initial begin
    logic [31:0] r32, cache_addr, exp_tgt;
    bit          busy, rr, clr, iss, irin, sf;
    int          cnt;
    logic [31:0] iaddr, iins;

    // reset, sequential fill, full stall, issue, freeze, bad address, flush, stale drop
    vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b1, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 1'b1, 32'h4,   1'b1, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 1'b1, 32'h8,   1'b1, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 1'b1, 32'hC,   1'b1, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b1, 32'h4};
    vt[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 1'b1, 32'h10,  1'b1, 32'h4};
    vt[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h4};
    vt[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 1'b1, 32'h10,  1'b1, 32'h4};
    vt[13] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h4};
    vt[14] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b0, 32'h0};
    vt[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 1'b0, 32'h100, 1'b0, 32'h0};
    vt[16] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
    vt[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
    vt[18] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h100};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rdy = vt[i].rdy; rob_clear = vt[i].clr; back_pc = vt[i].bpc;
      instr_ready_in = vt[i].irin; instr_addr_in = vt[i].iaddr; instr_in = 32'h13;
      instr_issued = vt[i].iss;
      #1;
      chk($sformatf("vec%0d_start_fetch", i), {31'd0, start_fetch}, {31'd0, vt[i].e_sf});
      chk($sformatf("vec%0d_fetch_pc", i), fetch_pc, vt[i].e_fpc);
      chk($sformatf("vec%0d_instr_ready", i), {31'd0, instr_ready}, {31'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d_instr_addr", i), instr_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_instr", i), instr, vt[i].e_rdy ? 32'h13 : 32'h0);
      chk($sformatf("vec%0d_pred", i), instr_pred_pc, vt[i].e_rdy ? vt[i].e_addr + 32'd4 : 32'h0);
    end

    // Full queue with tail at the wrap point: enqueue and issue in the same cycle.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h13, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1, m_fpc, 32'h13, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h13, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0, 1'b1, m_fpc, 32'h13, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1C, 32'h13, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("wrap_ready", {31'd0, instr_ready}, 32'd1);
      chk("wrap_order", instr_addr, 32'h10 + 32'(4 * k));
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h13, 1'b1);
    end
    #1 chk("wrap_drained", {31'd0, instr_ready}, 32'd0);

    // JAL at 0x20 with +0x40 offset, then a 5-cycle freeze with issue held high.
    exp_tgt = PRED_EN ? 32'h60 : 32'h24;
    step(1'b1, 1'b1, 32'h20, 1'b1, 32'hFFFF_FFF0, 32'h13, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h0400_006F, 1'b0);
    #1;
    chk("jal_fetch_pc", fetch_pc, exp_tgt);
    chk("jal_pred_pc", instr_pred_pc, exp_tgt);
    chk("jal_addr", instr_addr, 32'h20);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b1, exp_tgt, 32'h13, 1'b1);
    #1;
    chk("freeze_ready", {31'd0, instr_ready}, 32'd1);
    chk("freeze_addr", instr_addr, 32'h20);
    chk("freeze_fetch_pc", fetch_pc, exp_tgt);

    // Randomized traffic from a cache that answers each request after 1..3 cycles.
    do_reset();
    busy = 1'b0; cnt = 0; cache_addr = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      rr    = ($urandom % 10) != 0;
      clr   = ($urandom % 25) == 0;
      iss   = ($urandom % 2) == 1;
      irin  = 1'b0;
      iaddr = 32'h0;
      r32   = $urandom;
      iins  = (($urandom % 4) == 0) ? {r32[31:7], 7'b1101111} : r32;
      sf    = model_sf(rr);
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          irin = 1'b1; iaddr = cache_addr; busy = 1'b0;
        end
      end else if (sf) begin
        busy = 1'b1; cache_addr = m_fpc; cnt = $urandom_range(1, 3);
      end else if (($urandom % 30) == 0) begin
        irin = 1'b1; iaddr = (($urandom % 2) == 0) ? m_fpc : {$urandom} & 32'hFFFF_FFFC;
      end
      step(rr, clr, {$urandom} & 32'hFFFF_FFFC, irin, iaddr, iins, iss);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
